mem_fifo_seq: RTL

MEM_FIFO_SEQ -- requirements
Module: mem_fifo_seq

---
 rtl/mem_fifo_seq.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_fifo_seq.sv
// Sequencer wrapping a memory-core FIFO: config writes, flush, then streaming with a 2-entry read buffer.
// Optional peak-occupancy tracking is enabled with `define MEM_FIFO_SEQ_PEAK_EN.
module mem_fifo_seq #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int ALM_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [CNT_W-1:0]  cfg_depth,
   input  logic [ALM_W-1:0]  cfg_almost,
   output logic              cfg_busy,
   output logic              mc_clk_en,
   output logic              mc_flush,
   output logic              mc_config_write,
   output logic [31:0]       mc_config_addr,
   output logic [31:0]       mc_config_data,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              mc_wen,
   output logic [DATA_W-1:0] mc_data_in,
   output logic              mc_ren,
   input  logic              mc_valid_out,
   input  logic [DATA_W-1:0] mc_data_out,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data,
   output logic [CNT_W-1:0]  occupancy,
   output logic              full,
   output logic              empty,
   output logic              almost_full
`ifdef MEM_FIFO_SEQ_PEAK_EN
   ,
   output logic [CNT_W-1:0]  peak_occ
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CFG   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [1:0]          cfg_idx_q, cfg_idx_d;
   logic [CNT_W-1:0]    depth_q, depth_d;
   logic [ALM_W-1:0]    almost_q, almost_d;
   logic [CNT_W-1:0]    occ_q, occ_d;
   logic [DATA_W-1:0]   buf_q [2];
   logic [DATA_W-1:0]   buf_d [2];
   logic [1:0]          buf_cnt_q, buf_cnt_d;
   logic                inflight_q, inflight_d;
   logic                clk_en_q;

   logic                run_s, flush_s, empty_s, cfg_accept_s;
   logic                up_ready_s, wen_s, ren_s, push_s, pop_s, configured_s;
   logic [1:0]          outstanding_s;
   logic [CNT_W-1:0]    almost_ext_s, thresh_s;

   assign run_s         = (state_q == ST_RUN);
   assign flush_s       = (state_q == ST_FLUSH);
   assign configured_s  = (state_q != ST_IDLE);
   assign empty_s       = (occ_q == {CNT_W{1'b0}}) && (buf_cnt_q == 2'd0) && !inflight_q;
   assign cfg_accept_s  = cfg_start && ((state_q == ST_IDLE) || (run_s && empty_s));
   assign up_ready_s    = run_s && (occ_q < depth_q);
   assign wen_s         = up_valid && up_ready_s;
   // A read may only launch if its returning word is guaranteed a buffer slot.
   assign outstanding_s = buf_cnt_q + {1'b0, inflight_q};
   assign ren_s         = run_s && (occ_q != {CNT_W{1'b0}}) && (outstanding_s < 2'd2);
   assign push_s        = inflight_q && mc_valid_out;
   assign pop_s         = (buf_cnt_q != 2'd0) && dn_ready;
   assign almost_ext_s  = CNT_W'(almost_q);
   assign thresh_s      = (depth_q > almost_ext_s) ? (depth_q - almost_ext_s) : {CNT_W{1'b0}};

   assign up_ready    = up_ready_s;
   assign mc_wen      = wen_s;
   assign mc_ren      = ren_s;
   assign mc_data_in  = up_data;
   assign mc_clk_en   = clk_en_q;
   assign dn_valid    = (buf_cnt_q != 2'd0);
   assign dn_data     = buf_q[0];
   assign occupancy   = occ_q;
   assign empty       = empty_s;
   assign full        = configured_s && (occ_q == depth_q);
   assign almost_full = configured_s && (occ_q >= thresh_s);

   // State register and captured configuration.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cfg_idx_q <= 2'd0;
         depth_q   <= {CNT_W{1'b0}};
         almost_q  <= {ALM_W{1'b0}};
         clk_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_idx_q <= cfg_idx_d;
         depth_q   <= depth_d;
         almost_q  <= almost_d;
         clk_en_q  <= 1'b1;
      end
   end

   // Next-state logic and configuration capture.
   always_comb begin
      state_d   = state_q;
      cfg_idx_d = 2'd0;
      depth_d   = depth_q;
      almost_d  = almost_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_accept_s) state_d = ST_CFG;
            else              state_d = ST_IDLE;
         end
         ST_CFG: begin
            if (cfg_idx_q == 2'd2) begin
               state_d   = ST_FLUSH;
               cfg_idx_d = 2'd0;
            end else begin
               state_d   = ST_CFG;
               cfg_idx_d = cfg_idx_q + 2'd1;
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         ST_RUN: begin
            if (cfg_accept_s) state_d = ST_CFG;
            else              state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cfg_accept_s) begin
         depth_d  = (cfg_depth == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_depth;
         almost_d = cfg_almost;
      end else begin
         depth_d  = depth_q;
         almost_d = almost_q;
      end
   end

   // FSM-decoded configuration and flush outputs.
   always_comb begin
      cfg_busy        = (state_q == ST_CFG) || flush_s;
      mc_flush        = flush_s;
      mc_config_write = 1'b0;
      mc_config_addr  = 32'd0;
      mc_config_data  = 32'd0;
      if (state_q == ST_CFG) begin
         mc_config_write = 1'b1;
         mc_config_addr  = {30'd0, cfg_idx_q};
         case (cfg_idx_q)
            2'd0:    mc_config_data = 32'(depth_q);
            2'd1:    mc_config_data = 32'(almost_q);
            default: mc_config_data = 32'd1;
         endcase
      end else begin
         mc_config_write = 1'b0;
         mc_config_addr  = 32'd0;
         mc_config_data  = 32'd0;
      end
   end

   // Occupancy, read tracking and output buffer next state.
   always_comb begin
      occ_d      = occ_q;
      buf_d      = buf_q;
      buf_cnt_d  = buf_cnt_q;
      inflight_d = ren_s;
      if (flush_s) begin
         occ_d      = {CNT_W{1'b0}};
         buf_d[0]   = {DATA_W{1'b0}};
         buf_d[1]   = {DATA_W{1'b0}};
         buf_cnt_d  = 2'd0;
         inflight_d = 1'b0;
      end else begin
         case ({wen_s, ren_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
         endcase
         case ({push_s, pop_s})
            2'b10: begin
               buf_d[buf_cnt_q[0]] = mc_data_out;
               buf_cnt_d           = buf_cnt_q + 2'd1;
            end
            2'b01: begin
               buf_d[0]  = buf_q[1];
               buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
               if (buf_cnt_q == 2'd1) begin
                  buf_d[0] = mc_data_out;
               end else begin
                  buf_d[0] = buf_q[1];
                  buf_d[1] = mc_data_out;
               end
            end
            default: buf_cnt_d = buf_cnt_q;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= {CNT_W{1'b0}};
         buf_q[0]   <= {DATA_W{1'b0}};
         buf_q[1]   <= {DATA_W{1'b0}};
         buf_cnt_q  <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         occ_q      <= occ_d;
         buf_q[0]   <= buf_d[0];
         buf_q[1]   <= buf_d[1];
         buf_cnt_q  <= buf_cnt_d;
         inflight_q <= inflight_d;
      end
   end

`ifdef MEM_FIFO_SEQ_PEAK_EN
   logic [CNT_W-1:0] peak_q, peak_d;

   assign peak_occ = peak_q;

   // High-water mark of core occupancy, restarted by flush.
   always_comb begin
      if (flush_s)              peak_d = {CNT_W{1'b0}};
      else if (occ_d > peak_q)  peak_d = occ_d;
      else                      peak_d = peak_q;
   end

   // Peak register.
   always_ff @(posedge clk) begin
      if (reset) peak_q <= {CNT_W{1'b0}};
      else       peak_q <= peak_d;
   end
`endif

endmodule
